// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - two-requester arbiter for a six-digit seven-segment display
// Owner holds the display for HOLD_CYCLES after its last write; output path adds blanking and blink.
module hex_display_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_value,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_value,
  output logic        req1_ready,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [1:0]  owner
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          state, state_next;
  logic [HW-1:0]   hold_cnt, hold_next;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic [23:0]     value_reg;
  logic            shown;
  logic            xfer0, xfer1;
  logic            expired;
  logic [41:0]     hex_d, hex_q;
  logic            zero_run;

  assign expired = (hold_cnt == HOLD_MAX);
  assign owner   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer0      = 1'b0;
    xfer1      = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = 1'b1;
        req1_ready = !req0_valid;
        xfer0      = req0_valid;
        xfer1      = req1_valid && !req0_valid;
        hold_next  = '0;
        if (xfer0)      state_next = OWN0;
        else if (xfer1) state_next = OWN1;
      end
      OWN0: begin
        // Handover takes priority over the owner's write once the hold has run out.
        if (expired && req1_valid) begin
          state_next = OWN1;
          hold_next  = '0;
        end else begin
          req0_ready = 1'b1;
          xfer0      = req0_valid;
          if (xfer0)        hold_next  = '0;
          else if (expired) state_next = IDLE;
          else              hold_next  = hold_cnt + 1'b1;
        end
      end
      OWN1: begin
        if (expired && req0_valid) begin
          state_next = OWN0;
          hold_next  = '0;
        end else begin
          req1_ready = 1'b1;
          xfer1      = req1_valid;
          if (xfer1)        hold_next  = '0;
          else if (expired) state_next = IDLE;
          else              hold_next  = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= '0;
      shown     <= 1'b0;
    end else if (xfer0) begin
      value_reg <= req0_value;
      shown     <= 1'b1;
    end else if (xfer1) begin
      value_reg <= req1_value;
      shown     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= !blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] nib);
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction

  // zero_run stays high while every nibble from digit 5 down to the current one is zero.
  always_comb begin
    hex_d    = '1;
    zero_run = 1'b1;
    for (int d = 5; d >= 0; d--) begin
      zero_run = zero_run && (value_reg[4*d +: 4] == 4'h0);
      if (!shown || (blink_en && blink_phase))
        hex_d[7*d +: 7] = 7'h7F;
      else if (blank_lz && zero_run && (d != 0))
        hex_d[7*d +: 7] = 7'h7F;
      else
        hex_d[7*d +: 7] = seg(value_reg[4*d +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hex_q <= '1;
    else       hex_q <= hex_d;
  end

  assign hex0 = hex_q[6:0];
  assign hex1 = hex_q[13:7];
  assign hex2 = hex_q[20:14];
  assign hex3 = hex_q[27:21];
  assign hex4 = hex_q[34:28];
  assign hex5 = hex_q[41:35];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - scoreboard bench for hex_display_arbiter
// Stimulus queues cycle-stamped expectations; a negedge monitor compares them.
module tb_hex_display_arbiter;

  localparam int HOLD  = 4;
  localparam int BLINK = 8;
  localparam logic [41:0] BLANK = {6{7'h7F}};
  localparam logic [41:0] H123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] H789ABC = {7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46};
  localparam logic [41:0] HDEF012 = {7'h21, 7'h06, 7'h0E, 7'h40, 7'h79, 7'h24};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [23:0] req0_value = '0, req1_value = '0;
  logic        req0_ready, req1_ready;
  logic        blank_lz = 1'b0, blink_en = 1'b0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [1:0]  owner;

  hex_display_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BLINK)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_value(req0_value), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_value(req1_value), .req1_ready(req1_ready),
    .blank_lz(blank_lz), .blink_en(blink_en),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // kind: 0 owner, 1 hex5..hex0, 2 req0_ready, 3 req1_ready
  typedef struct {
    int          at;
    int          kind;
    logic [41:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   rst_last = 0;

  task automatic expect_at(input int dly, input int kind, input logic [41:0] val, input string name);
    exp_t e;
    e.at = cyc + dly;
    e.kind = kind;
    e.val = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [41:0] observe(input int kind);
    case (kind)
      0:       observe = {40'b0, owner};
      1:       observe = {hex5, hex4, hex3, hex2, hex1, hex0};
      2:       observe = {41'b0, req0_ready};
      default: observe = {41'b0, req1_ready};
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    int i;
    logic [41:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == cyc) begin
        act = observe(sb[i].kind);
        total++;
        if (act !== sb[i].val) begin
          bad++;
          $display("FAIL %s @cyc %0d: got %h want %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: expectation for cyc %0d never checked (now %0d)", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    // reset
    reset = 1'b1;
    step(2);
    rst_last = cyc;
    expect_at(0, 0, 42'd0, "reset_owner");
    expect_at(0, 1, BLANK, "reset_hex");
    expect_at(0, 2, 42'd1, "reset_ready0");
    expect_at(0, 3, 42'd1, "reset_ready1");
    reset = 1'b0;
    step(1);

    // single write from req0, then release to IDLE after the hold
    req0_valid = 1'b1; req0_value = 24'h123456;
    expect_at(0, 2, 42'd1, "w1_ready0");
    expect_at(1, 0, 42'd1, "w1_owner");
    expect_at(2, 1, H123456, "w1_hex");
    step(1);
    req0_valid = 1'b0;
    expect_at(3, 0, 42'd1, "w1_hold");
    expect_at(4, 0, 42'd0, "w1_release");
    expect_at(4, 1, H123456, "w1_persist");
    step(5);

    // both valid in IDLE: req0 wins, req1 takes over after the hold
    req0_valid = 1'b1; req0_value = 24'h789ABC;
    req1_valid = 1'b1; req1_value = 24'hDEF012;
    expect_at(0, 2, 42'd1, "both_ready0");
    expect_at(0, 3, 42'd0, "both_ready1");
    expect_at(1, 0, 42'd1, "both_grant0");
    step(1);
    req0_valid = 1'b0;
    expect_at(0, 3, 42'd0, "own0_ready1");
    expect_at(1, 1, H789ABC, "own0_hex");
    expect_at(3, 0, 42'd1, "own0_expired_owner");
    expect_at(3, 2, 42'd0, "own0_expired_ready0");
    expect_at(4, 0, 42'd2, "handover_owner");
    expect_at(5, 1, H789ABC, "handover_hex_old");
    expect_at(6, 1, HDEF012, "own1_hex");
    step(6);
    req1_valid = 1'b0;
    expect_at(4, 0, 42'd0, "own1_release");
    step(5);

    // owner keeps writing every other cycle so the hold never expires
    req0_valid = 1'b1; req0_value = 24'h111111;
    req1_valid = 1'b1; req1_value = 24'h222222;
    step(1);
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b0;
      expect_at(0, 0, 42'd1, "keep_owner_a");
      step(1);
      req0_valid = 1'b1;
      req0_value = 24'(24'h111111 * (i + 2));
      expect_at(0, 0, 42'd1, "keep_owner_b");
      step(1);
    end
    req0_valid = 1'b0;
    expect_at(1, 1, {6{7'h02}}, "keep_hex_last");
    expect_at(3, 0, 42'd1, "keep_last_hold");
    expect_at(4, 0, 42'd2, "keep_switch");
    expect_at(6, 1, {6{7'h24}}, "keep_hex_req1");
    step(5);
    req1_valid = 1'b0;
    step(5);

    // leading-zero blanking
    blank_lz = 1'b1;
    req0_valid = 1'b1; req0_value = 24'h000A05;
    step(1);
    req0_value = 24'h000000;
    step(1);
    req0_valid = 1'b0;
    expect_at(0, 1, {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12}, "lz_000a05");
    expect_at(1, 1, {{5{7'h7F}}, 7'h40}, "lz_000000");
    step(1);
    blank_lz = 1'b0;
    expect_at(1, 1, {6{7'h40}}, "lz_off_000000");
    step(5);

    // blink: phase derived from edges since the last reset edge
    req0_valid = 1'b1; req0_value = 24'h123456;
    step(1);
    req0_valid = 1'b0;
    step(5);
    blink_en = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      if ((((cyc + c - 1 - rst_last) / BLINK) % 2) == 1)
        expect_at(c, 1, BLANK, "blink_off_phase");
      else
        expect_at(c, 1, H123456, "blink_on_phase");
    end
    step(32);
    blink_en = 1'b0;
    for (int c = 1; c <= 8; c++) expect_at(c, 1, H123456, "blink_disabled");
    step(8);

    // reset while req1 owns and both are valid
    req1_valid = 1'b1; req1_value = 24'hABCDEF;
    step(1);
    req0_valid = 1'b1; req0_value = 24'h000001;
    expect_at(0, 0, 42'd2, "prerst_owner");
    expect_at(0, 2, 42'd0, "prerst_ready0");
    step(1);
    reset = 1'b1;
    expect_at(0, 0, 42'd2, "prerst_owner_held");
    step(1);
    rst_last = cyc;
    reset = 1'b0;
    expect_at(0, 0, 42'd0, "rst_owner");
    expect_at(0, 1, BLANK, "rst_hex");
    expect_at(0, 2, 42'd1, "rst_ready0");
    expect_at(0, 3, 42'd0, "rst_ready1");
    expect_at(1, 0, 42'd1, "rst_grant0");
    expect_at(1, 1, BLANK, "rst_hex_pending");
    expect_at(2, 1, {{5{7'h40}}, 7'h79}, "rst_hex_new");
    step(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step(6);

    for (int w = 0; w < 20 && sb.size() > 0; w++) step(1);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      total += sb.size();
      bad += sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
